// File: rtl/apb_regfile_pkg.sv
// apb_regfile_pkg
//   Shared definitions for the APB-to-register-file bridge:
//   default geometry constants and the bridge FSM state encoding.
package apb_regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/apb_regfile_bridge.sv
// apb_regfile_bridge
//   APB slave that turns each transfer into a single register-file access.
//   Every transfer takes a fixed 3 cycles: setup (T0), WRITE/READ (T1),
//   RESP with pready (T2). All state and outputs come straight from flops.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     psel/penable/pwrite       APB control
//     paddr/pwdata/pstrb        APB address (word index), data, byte strobes
//     pready/prdata/pslverr     APB response (prdata registered)
//     wr_en_0/wr_addr_0/        register-file write port
//       wr_data_0/wr_be_0
//     rd_addr_0/rd_data_0       register-file read port (combinational data)
//
//   Build option
//     APB_REGFILE_BRIDGE_PSTRB_EN  when defined, pstrb drives wr_be_0 and an
//                                  all-zero strobe suppresses the write;
//                                  otherwise every write is full-word.
module apb_regfile_bridge
  import apb_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    wr_en_0,
  output logic [ADDR_WIDTH-1:0]   wr_addr_0,
  output logic [DATA_WIDTH-1:0]   wr_data_0,
  output logic [DATA_WIDTH/8-1:0] wr_be_0,
  output logic [ADDR_WIDTH-1:0]   rd_addr_0,
  input  logic [DATA_WIDTH-1:0]   rd_data_0
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);

  state_e                  state_q, state_d;
  logic                    err_q, err_d;       // latched "address out of range"
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [SW-1:0]           wr_be_q, wr_be_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;

  // Byte-enable source and whether the strobes permit a write at all.
  logic [SW-1:0] be_sel;
  logic          strb_ok;

`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
  assign be_sel  = pstrb;
  assign strb_ok = |pstrb;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign be_sel  = '1;
  assign strb_ok = 1'b1;
`endif

  // The setup phase loads the register-file port flops directly, so that
  // wr_en_0 / rd_addr_0 are already valid during the one-cycle WRITE/READ.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    rd_addr_d = rd_addr_q;

    case (state_q)
      IDLE: begin
        // Access phase without a preceding setup is ignored.
        if (psel && !penable) begin
          err_d = (paddr >= REG_LIMIT);
          if (pwrite) begin
            state_d   = WRITE;
            wr_en_d   = (paddr < REG_LIMIT) && strb_ok;
            wr_addr_d = paddr;
            wr_data_d = pwdata;
            wr_be_d   = be_sel;
          end else begin
            state_d   = READ;
            rd_addr_d = paddr;
          end
        end
      end
      WRITE: begin
        state_d   = RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q;
      end
      READ: begin
        state_d   = RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q;
        prdata_d  = err_q ? '0 : rd_data_0;
      end
      RESP: begin
        // A new setup here is dropped; the master waits for pready first.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign wr_en_0   = wr_en_q;
  assign wr_addr_0 = wr_addr_q;
  assign wr_data_0 = wr_data_q;
  assign wr_be_0   = wr_be_q;
  assign rd_addr_0 = rd_addr_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// tb_apb_regfile_bridge
//   Drives APB transfers (directed then random) into apb_regfile_bridge,
//   with a small register file hanging off its write/read ports. A reference
//   model predicts each register-file write and each APB response into
//   queues; a negedge monitor pops and compares whenever the DUT shows
//   wr_en_0 or pready.
module tb_apb_regfile_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 6;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          wr_en_0;
  logic [AW-1:0] wr_addr_0, rd_addr_0;
  logic [DW-1:0] wr_data_0, rd_data_0;
  logic [SW-1:0] wr_be_0;

  always #5 clk = ~clk;

  apb_regfile_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .wr_en_0(wr_en_0),
    .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0), .wr_be_0(wr_be_0),
    .rd_addr_0(rd_addr_0), .rd_data_0(rd_data_0)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] be; } wexp_t;
  typedef struct { logic [DW-1:0] rd; logic err; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int total = 0;
  int bad   = 0;

  // Reference state: register contents and the last value read over APB.
  logic [DW-1:0] shadow [0:7];
  logic [DW-1:0] last_rd;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Register file environment: cleared by reset, written by the DUT.
  logic [DW-1:0] rf [0:7];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr_en_0 && wr_addr_0 < NR) begin
      rf[wr_addr_0[2:0]] <= merge(rf[wr_addr_0[2:0]], wr_data_0, wr_be_0);
    end
  end
  // Out-of-range reads return garbage so the forced-zero capture is visible.
  assign rd_data_0 = (rd_addr_0 < NR) ? rf[rd_addr_0[2:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: asserted with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_0) begin
        if (wq.size() == 0) unexpected("wr_en_0");
        else begin
          wexp_t w;
          w = wq.pop_front();
          chk("wr_addr_0", wr_addr_0, w.a);
          chk("wr_data_0", wr_data_0, w.d);
          chk("wr_be_0", wr_be_0, w.be);
        end
      end
      if (pready) begin
        if (rq.size() == 0) unexpected("pready");
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("prdata", prdata, r.rd);
          chk("pslverr", pslverr, r.err);
        end
      end else if (pslverr) begin
        unexpected("pslverr_without_pready");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    wq.delete();
    rq.delete();
    last_rd = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    step();
    step();
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_wr_en", wr_en_0, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_wr_addr", wr_addr_0, 0);
    chk("rst_wr_data", wr_data_0, 0);
    chk("rst_wr_be", wr_be_0, 0);
    chk("rst_rd_addr", rd_addr_0, 0);
    rst = 1'b0;
    clear_model();
  endtask

  // One APB transfer; expectations are queued before the setup phase.
  // drop=1 releases psel/penable during T1 (must not abort the transfer).
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input bit drop);
    bit oob;
    int n;
    rexp_t r;
    wexp_t w;
    oob = (a >= NR);
    if (wr) begin
`ifdef APB_REGFILE_BRIDGE_PSTRB_EN
      w.be = s;
`else
      w.be = '1;
`endif
      if (!oob && w.be != 0) begin
        w.a = a; w.d = d;
        wq.push_back(w);
        shadow[a[2:0]] = merge(shadow[a[2:0]], d, w.be);
      end
      r.rd = last_rd;
    end else begin
      r.rd = oob ? '0 : shadow[a[2:0]];
      last_rd = r.rd;
    end
    r.err = oob;
    rq.push_back(r);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    step();
    n = 1;
    if (!wr) chk("rd_addr_0_T1", rd_addr_0, a);
    if (drop) begin psel = 1'b0; penable = 1'b0; end
    else penable = 1'b1;
    while (!pready && n < 8) begin
      step();
      n++;
    end
    chk("pready_latency", n, 2);
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    do_reset();
    step();

    // Directed cases.
    xfer(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 1'b0);
    xfer(1'b1, 8'h04, 32'h00010000, 4'hF, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 8'h10, 32'h12345678, 4'hF, 1'b0);   // out of range write
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);          // out of range read
    xfer(1'b1, 8'h03, 32'hA5A5A5A5, 4'h0, 1'b0);   // zero strobes
    xfer(1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
    xfer(1'b0, 8'h05, 32'h0, 4'h0, 1'b0);          // last valid index
    xfer(1'b0, 8'h06, 32'h0, 4'h0, 1'b0);          // first invalid index
    xfer(1'b1, 8'h01, 32'hCAFEF00D, 4'h5, 1'b1);   // psel dropped during WRITE
    xfer(1'b0, 8'h01, 32'h0, 4'h0, 1'b1);          // psel dropped during READ

    // Access phase without setup in IDLE: nothing may happen.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h02; pwdata = 32'hFFFF0000; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("noset_pready", pready, 0);
      chk("noset_wr_en", wr_en_0, 0);
    end
    psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 8'h02, 32'h0, 4'h0, 1'b0);

    // Reset sampled at the setup edge of a write: no WRITE, no response.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 32'h11112222; pstrb = 4'hF;
    rst = 1'b1;
    step();
    chk("rstw_wr_en", wr_en_0, 0);
    chk("rstw_pready", pready, 0);
    chk("rstw_wr_data", wr_data_0, 0);
    chk("rstw_prdata", prdata, 0);
    rst = 1'b0; psel = 1'b0;
    clear_model();
    repeat (3) step();
    xfer(1'b0, 8'h01, 32'h0, 4'h0, 1'b0);

    // Reset while in READ: the response must never appear.
    xfer(1'b1, 8'h02, 32'h13579BDF, 4'hF, 1'b0);
    xfer(1'b0, 8'h02, 32'h0, 4'h0, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h02;
    step();
    penable = 1'b1; rst = 1'b1;
    step();
    chk("rstr_pready", pready, 0);
    chk("rstr_prdata", prdata, 0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    clear_model();
    repeat (3) step();

    // Randomized traffic with idle gaps and stray no-setup access cycles.
    for (int i = 0; i < 200; i++) begin
      bit wr;
      logic [AW-1:0] a;
      wr = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(NR, 255)) : AW'($urandom_range(0, NR-1));
      xfer(wr, a, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: ;
        1: step();
        2: begin
          psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
          paddr = AW'($urandom_range(0, NR-1)); pwdata = $urandom; pstrb = 4'hF;
          step();
          psel = 1'b0; penable = 1'b0;
        end
        default: repeat (2) step();
      endcase
    end

    // Back-to-back burst, then drain.
    for (int i = 0; i < NR; i++) xfer(1'b1, AW'(i), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < NR; i++) xfer(1'b0, AW'(i), 32'h0, 4'h0, 1'b0);
    repeat (4) step();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_regfile_bridge.md
APB_REGFILE_BRIDGE -- requirements
Module: apb_regfile_bridge

Interface
REQ-001 Parameters: ADDR_WIDTH, default 8, register address width; DATA_WIDTH, default 32, data width; NUM_REGS, default 6, count of decoded word addresses 0..NUM_REGS-1.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  ADDR_WIDTH  word address.
REQ-009 pwdata  input  DATA_WIDTH  write data.
REQ-010 pstrb  input  DATA_WIDTH/8  byte strobes.
REQ-011 pready  output  1  transfer complete.
REQ-012 prdata  output  DATA_WIDTH  read data, registered.
REQ-013 pslverr  output  1  error response, valid with pready.
REQ-014 wr_en_0  output  1  register-file write strobe.
REQ-015 wr_addr_0  output  ADDR_WIDTH  register-file write address.
REQ-016 wr_data_0  output  DATA_WIDTH  register-file write data.
REQ-017 wr_be_0  output  DATA_WIDTH/8  register-file byte enables.
REQ-018 rd_addr_0  output  ADDR_WIDTH  register-file read address.
REQ-019 rd_data_0  input  DATA_WIDTH  combinational read data from the register file.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, READ and RESP, all state and outputs being registered.
REQ-021 In IDLE, psel=1 with penable=0 SHALL latch paddr, pwdata, pstrb and pwrite, then move to WRITE when pwrite=1 or to READ when pwrite=0.
REQ-022 In IDLE, psel=1 with penable=1 (access without setup) SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-023 WRITE SHALL be held for exactly one cycle: wr_en_0=1 with the latched address, data and strobes, then RESP.
REQ-024 wr_en_0 SHALL stay 0 in WRITE when the latched pstrb is all-zero or the latched paddr>=NUM_REGS.
REQ-025 READ SHALL be held for exactly one cycle: rd_addr_0 driven with the latched paddr; at the end of the cycle, rd_data_0 is captured into prdata, or 0 is captured when paddr>=NUM_REGS; then RESP.
REQ-026 RESP SHALL be held for exactly one cycle with pready=1 and pslverr=(latched paddr>=NUM_REGS), then IDLE.
REQ-027 Timing SHALL be setup T0, WRITE/READ T1, pready at T2: one wait state and a fixed 3-cycle transfer.
REQ-028 pready and pslverr SHALL be 0 in every state other than RESP.
REQ-029 wr_en_0 SHALL be 0 in every state other than WRITE.
REQ-030 prdata SHALL hold its last value until the next READ, and SHALL be unchanged by writes.
REQ-031 rd_addr_0, wr_addr_0, wr_data_0 and wr_be_0 SHALL hold their last values outside READ/WRITE.
REQ-032 psel deasserting during WRITE/READ/RESP SHALL NOT abort the sequence; a write already in WRITE is committed.
REQ-033 A new setup presented during RESP SHALL be ignored; a master may only start the next transfer after sampling pready=1.

Reset
REQ-034 When rst=1 at a rising edge, the FSM SHALL go to IDLE and pready, pslverr, wr_en_0, prdata, wr_addr_0, wr_data_0, wr_be_0 and rd_addr_0 SHALL be 0.
REQ-035 Reset mid-transfer SHALL discard the transfer: no wr_en_0 pulse and no pready after rst.

Configuration
REQ-036 With APB_REGFILE_BRIDGE_PSTRB_EN defined, wr_be_0 SHALL be the latched pstrb and REQ-024's all-zero-strobe suppression SHALL apply.
REQ-037 Without APB_REGFILE_BRIDGE_PSTRB_EN, pstrb SHALL be ignored and wr_be_0 SHALL be all ones on every write.

Structure
REQ-038 Package apb_regfile_pkg SHALL hold the FSM state enum (IDLE/WRITE/READ/RESP) and the default ADDR_WIDTH/DATA_WIDTH/NUM_REGS constants.
REQ-039 The block SHALL be a single module with no sub-module.

Verification
REQ-040 Write paddr=0x00, pwdata=0xDEADBEEF, pstrb=4'hF -> wr_en_0 high for exactly one cycle at T1 with matching address, data and be=4'hF; pready=1 and pslverr=0 at T2.
REQ-041 Read paddr=0x04 with rd_data_0 tied to 0x00010000 -> rd_addr_0=0x04 at T1; prdata=0x00010000 with pready=1 at T2.
REQ-042 Write paddr=0x10 (NUM_REGS=6) -> no wr_en_0 pulse; pready=1 and pslverr=1 at T2. Read paddr=0x10 -> prdata=0 and pslverr=1.
REQ-043 Write with pstrb=4'h0: with the macro -> no wr_en_0 and pready=1; without the macro -> wr_en_0 with wr_be_0=4'hF.
REQ-044 rst asserted at T1 of a write -> no wr_en_0, no pready, all outputs 0 next cycle, FSM in IDLE.
REQ-045 psel=1 with penable=1 while in IDLE -> no state change and no outputs; back-to-back transfers -> each takes 3 cycles with pready exactly once.
